// File: rtl/apb_soc_ctrl_mc_if.sv
// APB slave bundle for the multi-cluster SoC control block.
interface apb_soc_ctrl_mc_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_soc_ctrl_mc.sv
// SoC control registers with per-cluster power sequencers, boot-address lock
// and PSLVERR signalling for bad or locked accesses.
module apb_soc_ctrl_mc #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NB_CLUSTERS    = 2,
  parameter int unsigned NB_CORES       = 8,
  parameter int unsigned JTAG_REG_SIZE  = 8,
  parameter int unsigned SEQ_WAIT       = 4,
  parameter logic [31:0] BOOTADDR_RST   = 32'h1A000080
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  apb_soc_ctrl_mc_if.slave           apb,
  input  logic                       fc_fetch_en_valid_i,
  input  logic                       fc_fetch_en_i,
  input  logic [JTAG_REG_SIZE-1:0]   soc_jtag_reg_i,
  output logic [JTAG_REG_SIZE-1:0]   soc_jtag_reg_o,
  output logic [31:0]                fc_bootaddr_o,
  output logic                       fc_fetchen_o,
  output logic                       eoc_o,
  input  logic [NB_CLUSTERS-1:0]     cluster_pwr_ack_i,
  output logic [NB_CLUSTERS-1:0]     cluster_pow_o,
  output logic [NB_CLUSTERS-1:0]     cluster_byp_o,
  output logic [NB_CLUSTERS-1:0]     cluster_rstn_o,
  output logic [NB_CLUSTERS-1:0]     cluster_fetch_enable_o,
  output logic [NB_CLUSTERS-1:0]     cluster_irq_o,
  output logic [32*NB_CLUSTERS-1:0]  cluster_boot_addr_o
);
  localparam int unsigned CW      = $clog2(SEQ_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(SEQ_WAIT - 1);
  localparam logic [31:0] INFO    = {16'(NB_CORES), 16'(NB_CLUSTERS)};

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_PWR_UP     = 3'd1,
    S_ISO_REL    = 3'd2,
    S_RST_REL    = 3'd3,
    S_RUN        = 3'd4,
    S_FETCH_DIS  = 3'd5,
    S_RST_ASSERT = 3'd6,
    S_PWR_DN     = 3'd7
  } seq_state_e;

  logic                     acc, wr, err, hit;
  logic [6:0]               widx;
  logic [31:0]              rdata;
  logic                     we_fcboot, we_fcfetch, we_jtag, we_lock, we_cs;
  logic [NB_CLUSTERS-1:0]   we_ctrl, we_boot, we_irq;

  logic [31:0]              fcboot_q, cs_q;
  logic                     fcfetch_q, lock_q;
  logic [JTAG_REG_SIZE-1:0] jtag_q, jtag_s1_q, jtag_s2_q;
  logic [NB_CLUSTERS-1:0]   req_q, irq_q, ack_s1_q, ack_s2_q, busy;
  logic [NB_CLUSTERS-1:0]   pow_q, byp_q, rstn_q, cfetch_q;
  logic [31:0]              boot_q  [NB_CLUSTERS];
  seq_state_e               state_q [NB_CLUSTERS];
  seq_state_e               state_d [NB_CLUSTERS];
  logic [CW-1:0]            cnt_q   [NB_CLUSTERS];
  logic [CW-1:0]            cnt_d   [NB_CLUSTERS];

  assign acc  = apb.PSEL & apb.PENABLE;
  assign wr   = acc & apb.PWRITE;
  assign widx = apb.PADDR[8:2];

  generate
    if (APB_ADDR_WIDTH > 9) begin : g_hi
      logic unused_addr;
      assign unused_addr = ^{apb.PADDR[APB_ADDR_WIDTH-1:9], apb.PADDR[1:0]};
    end else begin : g_lo
      logic unused_addr;
      assign unused_addr = ^apb.PADDR[1:0];
    end
  endgenerate

  always_comb begin
    for (int unsigned k = 0; k < NB_CLUSTERS; k++)
      busy[k] = !(state_q[k] == S_OFF || state_q[k] == S_RUN);
  end

  // Write strobes are only raised for accesses that will not error, so an
  // erroring access leaves all state untouched.
  always_comb begin
    rdata = '0; err = 1'b0; hit = 1'b0;
    we_fcboot = 1'b0; we_fcfetch = 1'b0; we_jtag = 1'b0; we_lock = 1'b0; we_cs = 1'b0;
    we_ctrl = '0; we_boot = '0; we_irq = '0;
    if (widx[6:5] == 2'b10) begin
      for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
        if (widx[4:2] == k[2:0]) begin
          hit = 1'b1;
          case (widx[1:0])
            2'd0: begin rdata = {25'b0, state_q[k], 2'b0, busy[k], req_q[k]}; we_ctrl[k] = wr; end
            2'd1: begin
              rdata = boot_q[k];
              if (wr && lock_q) err = 1'b1;
              else              we_boot[k] = wr;
            end
            2'd2: begin rdata = {31'b0, irq_q[k]}; we_irq[k] = wr; end
            default: err = 1'b1;
          endcase
        end
      end
      if (!hit) err = 1'b1;
    end else begin
      case (widx)
        7'd0:  begin rdata = INFO; err = wr; end
        7'd1:  begin
          rdata = fcboot_q;
          if (wr && lock_q) err = 1'b1;
          else              we_fcboot = wr;
        end
        7'd2:  begin rdata = {31'b0, fcfetch_q}; we_fcfetch = wr; end
        7'd29: begin rdata[2*JTAG_REG_SIZE-1:0] = {jtag_s2_q, jtag_q}; we_jtag = wr; end
        7'd31: begin rdata = {31'b0, lock_q}; we_lock = wr; end
        7'd40: begin rdata = cs_q; we_cs = wr; end
        7'd48: begin rdata = cs_q; err = wr; end
        default: err = 1'b1;
      endcase
    end
    if (!acc) err = 1'b0;
    if (err)  rdata = '0;
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fcboot_q  <= BOOTADDR_RST;
      fcfetch_q <= 1'b0;
      jtag_q    <= '0;
      jtag_s1_q <= '0;
      jtag_s2_q <= '0;
      lock_q    <= 1'b0;
      cs_q      <= '0;
      req_q     <= '0;
      irq_q     <= '0;
      ack_s1_q  <= '0;
      ack_s2_q  <= '0;
      for (int unsigned k = 0; k < NB_CLUSTERS; k++) boot_q[k] <= '0;
    end else begin
      jtag_s1_q <= soc_jtag_reg_i;
      jtag_s2_q <= jtag_s1_q;
      ack_s1_q  <= cluster_pwr_ack_i;
      ack_s2_q  <= ack_s1_q;
      if (we_fcboot) fcboot_q <= apb.PWDATA;
      if (fc_fetch_en_valid_i) fcfetch_q <= fc_fetch_en_i;
      else if (we_fcfetch)     fcfetch_q <= apb.PWDATA[0];
      if (we_jtag) jtag_q <= apb.PWDATA[JTAG_REG_SIZE-1:0];
      if (we_lock && apb.PWDATA[0]) lock_q <= 1'b1;
      if (we_cs) cs_q <= apb.PWDATA;
      for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
        if (we_ctrl[k]) req_q[k]  <= apb.PWDATA[0];
        if (we_boot[k]) boot_q[k] <= apb.PWDATA;
        if (we_irq[k])  irq_q[k]  <= apb.PWDATA[0];
      end
    end
  end

  // {pow, byp, rstn, fetch} for each sequencer state
  function automatic logic [3:0] seq_out(input seq_state_e s);
    case (s)
      S_PWR_UP:     seq_out = 4'b1100;
      S_ISO_REL:    seq_out = 4'b1000;
      S_RST_REL:    seq_out = 4'b1010;
      S_RUN:        seq_out = 4'b1011;
      S_FETCH_DIS:  seq_out = 4'b1010;
      S_RST_ASSERT: seq_out = 4'b1100;
      default:      seq_out = 4'b0100;
    endcase
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        S_OFF:        if (req_q[k])         state_d[k] = S_PWR_UP;
        S_PWR_UP:     if (ack_s2_q[k])      state_d[k] = S_ISO_REL;
        S_ISO_REL:    if (cnt_q[k] == '0)   state_d[k] = S_RST_REL;
        S_RST_REL:    if (cnt_q[k] == '0)   state_d[k] = S_RUN;
        S_RUN:        if (!req_q[k])        state_d[k] = S_FETCH_DIS;
        S_FETCH_DIS:  if (cnt_q[k] == '0)   state_d[k] = S_RST_ASSERT;
        S_RST_ASSERT: if (cnt_q[k] == '0)   state_d[k] = S_PWR_DN;
        S_PWR_DN:     if (!ack_s2_q[k])     state_d[k] = S_OFF;
        default:                            state_d[k] = S_OFF;
      endcase
      // Counter reloads on every state change and saturates at zero.
      if (state_d[k] != state_q[k]) cnt_d[k] = WAIT_LD;
      else if (cnt_q[k] != '0)      cnt_d[k] = cnt_q[k] - CW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
        state_q[k] <= S_OFF;
        cnt_q[k]   <= '0;
      end
      pow_q    <= '0;
      byp_q    <= '1;
      rstn_q   <= '0;
      cfetch_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NB_CLUSTERS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        {pow_q[k], byp_q[k], rstn_q[k], cfetch_q[k]} <= seq_out(state_d[k]);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NB_CLUSTERS; k++)
      cluster_boot_addr_o[32*k +: 32] = boot_q[k];
  end

  assign soc_jtag_reg_o         = jtag_q;
  assign fc_bootaddr_o          = fcboot_q;
  assign fc_fetchen_o           = fcfetch_q;
  assign eoc_o                  = cs_q[31];
  assign cluster_pow_o          = pow_q;
  assign cluster_byp_o          = byp_q;
  assign cluster_rstn_o         = rstn_q;
  assign cluster_fetch_enable_o = cfetch_q;
  assign cluster_irq_o          = irq_q;
endmodule

// File: tb/tb_apb_soc_ctrl_mc.sv
// Bench for apb_soc_ctrl_mc: vector tables, timed sequencer walks and a
// randomized register-traffic run against a register-level model.
module tb_apb_soc_ctrl_mc;
  localparam int W = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        fc_fetch_en_valid_i, fc_fetch_en_i;
  logic [7:0]  soc_jtag_reg_i, soc_jtag_reg_o;
  logic [31:0] fc_bootaddr_o;
  logic        fc_fetchen_o, eoc_o;
  logic [1:0]  cluster_pwr_ack_i, pow, byp, rstn, fen, irq;
  logic [63:0] boot_o;
  logic        ack_tie;
  logic [1:0]  ack_man;

  always #5 HCLK = ~HCLK;

  assign cluster_pwr_ack_i = ack_tie ? pow : ack_man;

  apb_soc_ctrl_mc_if #(.APB_ADDR_WIDTH(12)) apb ();

  apb_soc_ctrl_mc #(
    .APB_ADDR_WIDTH(12), .NB_CLUSTERS(2), .NB_CORES(8), .JTAG_REG_SIZE(8),
    .SEQ_WAIT(W), .BOOTADDR_RST(32'h1A000080)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .apb(apb),
    .fc_fetch_en_valid_i(fc_fetch_en_valid_i), .fc_fetch_en_i(fc_fetch_en_i),
    .soc_jtag_reg_i(soc_jtag_reg_i), .soc_jtag_reg_o(soc_jtag_reg_o),
    .fc_bootaddr_o(fc_bootaddr_o), .fc_fetchen_o(fc_fetchen_o), .eoc_o(eoc_o),
    .cluster_pwr_ack_i(cluster_pwr_ack_i), .cluster_pow_o(pow), .cluster_byp_o(byp),
    .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fen), .cluster_irq_o(irq),
    .cluster_boot_addr_o(boot_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge HCLK);
    rd = apb.PRDATA; e = apb.PSLVERR;
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  function automatic logic [7:0] cl_outs();
    return {pow[1], byp[1], rstn[1], fen[1], pow[0], byp[0], rstn[0], fen[0]};
  endfunction

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;
  vec_t vt [$];

  task automatic add(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic e, input logic [31:0] r);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.eerr = e; v.erd = r;
    vt.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic [31:0] rd;
    logic e;
    for (int i = lo; i < hi; i++) begin
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].data, rd, e);
      chk($sformatf("vec%0d_err@%h", i, vt[i].addr), 64'(e), 64'(vt[i].eerr));
      if (!vt[i].wr) chk($sformatf("vec%0d_rd@%h", i, vt[i].addr), 64'(rd), 64'(vt[i].erd));
    end
  endtask

  // Register-level model used by the randomized run
  logic [31:0] m_fcboot, m_cs;
  logic        m_fetch, m_lock;
  logic [7:0]  m_jtag;
  logic [31:0] m_boot [2];
  logic [1:0]  m_irq;

  task automatic model_acc(input logic w, input logic [11:0] a, input logic [31:0] d,
                           output logic e, output logic [31:0] r);
    int off, k, sub;
    off = int'(a[8:2]) * 4;
    e = 1'b0; r = '0;
    if (off >= 256 && off < 384) begin
      k = (off - 256) / 16; sub = (off % 16) / 4;
      if (k >= 2 || sub == 3) e = 1'b1;
      else if (sub == 0) r = 32'h0;
      else if (sub == 1) begin
        if (w && m_lock) e = 1'b1;
        else begin if (w) m_boot[k] = d; r = m_boot[k]; end
      end else begin
        if (w) m_irq[k] = d[0];
        r = {31'b0, m_irq[k]};
      end
    end else begin
      case (off)
        'h000: begin e = w; r = 32'h00080002; end
        'h004: if (w && m_lock) e = 1'b1; else begin if (w) m_fcboot = d; r = m_fcboot; end
        'h008: begin if (w) m_fetch = d[0]; r = {31'b0, m_fetch}; end
        'h074: begin if (w) m_jtag = d[7:0]; r = {16'b0, soc_jtag_reg_i, m_jtag}; end
        'h07C: begin if (w && d[0]) m_lock = 1'b1; r = {31'b0, m_lock}; end
        'h0A0: begin if (w) m_cs = d; r = m_cs; end
        'h0C0: begin e = w; r = m_cs; end
        default: e = 1'b1;
      endcase
    end
    if (e) r = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd, d;
    logic        e, ee, w;
    logic [11:0] a;
    logic [8:0]  offs [23];
    logic [3:0]  x0;
    int          n_t1;

    offs = '{9'h000, 9'h004, 9'h008, 9'h074, 9'h07C, 9'h0A0, 9'h0C0, 9'h100, 9'h104,
             9'h108, 9'h10C, 9'h110, 9'h114, 9'h118, 9'h11C, 9'h120, 9'h124, 9'h170,
             9'h00C, 9'h078, 9'h0A4, 9'h180, 9'h1FC};

    // Reset-state reads
    add(0, 12'h000, 0, 0, 32'h00080002);
    add(0, 12'h004, 0, 0, 32'h1A000080);
    add(0, 12'h008, 0, 0, 32'h0);
    add(0, 12'h074, 0, 0, 32'h00005A00);
    add(0, 12'h07C, 0, 0, 32'h0);
    add(0, 12'h0A0, 0, 0, 32'h0);
    add(0, 12'h0C0, 0, 0, 32'h0);
    add(0, 12'h100, 0, 0, 32'h0);
    add(0, 12'h104, 0, 0, 32'h0);
    add(0, 12'h108, 0, 0, 32'h0);
    add(0, 12'h110, 0, 0, 32'h0);
    add(0, 12'h114, 0, 0, 32'h0);
    add(0, 12'h118, 0, 0, 32'h0);
    n_t1 = vt.size();
    // Lock, illegal accesses, status mirror
    add(1, 12'h07C, 32'h1,        0, 32'h0);
    add(1, 12'h004, 32'h1C000000, 1, 32'h0);
    add(0, 12'h004, 0,            0, 32'h1A000080);
    add(1, 12'h07C, 32'h0,        0, 32'h0);
    add(0, 12'h07C, 0,            0, 32'h1);
    add(1, 12'h104, 32'h1234,     1, 32'h0);
    add(0, 12'h104, 0,            0, 32'h0);
    add(1, 12'h120, 32'h1,        1, 32'h0);
    add(1, 12'h000, 32'h0,        1, 32'h0);
    add(0, 12'h10C, 0,            1, 32'h0);
    add(0, 12'h120, 0,            1, 32'h0);
    add(1, 12'h0C0, 32'h5,        1, 32'h0);
    add(0, 12'h100, 0,            0, 32'h0);
    add(1, 12'h0A0, 32'h80000001, 0, 32'h0);
    add(0, 12'h0C0, 0,            0, 32'h80000001);
    add(0, 12'h0A0, 0,            0, 32'h80000001);

    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
    fc_fetch_en_valid_i = 0; fc_fetch_en_i = 0; soc_jtag_reg_i = 8'h5A;
    ack_tie = 1'b1; ack_man = 2'b00;
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;

    chk("rst_outs", 64'(cl_outs()), 64'h44);
    chk("rst_fcboot", 64'(fc_bootaddr_o), 64'h1A000080);
    chk("rst_misc", 64'({fc_fetchen_o, eoc_o, irq, soc_jtag_reg_o}), 64'h0);
    chk("rst_boot", boot_o, 64'h0);
    run_vecs(0, n_t1);

    // Pin override beats a simultaneous APB write
    fc_fetch_en_valid_i = 1; fc_fetch_en_i = 1;
    apb_xfer(1, 12'h008, 32'h0, rd, e);
    fc_fetch_en_valid_i = 0;
    chk("pin_win", 64'(fc_fetchen_o), 64'h1);
    apb_xfer(0, 12'h008, 0, rd, e);
    chk("pin_rd", 64'(rd), 64'h1);
    fc_fetch_en_i = 0; fc_fetch_en_valid_i = 1;
    @(posedge HCLK); #1;
    fc_fetch_en_valid_i = 0;
    chk("pin_clr", 64'(fc_fetchen_o), 64'h0);

    // Power-up walk, ack tied to pow
    apb_xfer(1, 12'h100, 32'h1, rd, e);
    for (int n = 1; n <= 14; n++) begin
      @(posedge HCLK); #1;
      x0 = {1'b1, n < 4, n >= 4 + W, n >= 4 + 2 * W};
      chk($sformatf("up_E%0d", n), 64'(cl_outs()), 64'({4'b0100, x0}));
    end
    apb_xfer(0, 12'h100, 0, rd, e);
    chk("run_ctrl", 64'(rd), 64'h41);

    // Power-down walk, ack held by the bench
    ack_man = 2'b01; ack_tie = 1'b0;
    apb_xfer(1, 12'h100, 32'h0, rd, e);
    for (int n = 1; n <= 10; n++) begin
      @(posedge HCLK); #1;
      x0 = {n < 1 + 2 * W, n >= 1 + W, n < 1 + W, 1'b0};
      chk($sformatf("dn_E%0d", n), 64'(cl_outs()), 64'({4'b0100, x0}));
    end
    apb_xfer(0, 12'h100, 0, rd, e);
    chk("pwrdn_ctrl", 64'(rd), 64'h72);
    ack_man = 2'b00;
    repeat (4) @(posedge HCLK);
    apb_xfer(0, 12'h100, 0, rd, e);
    chk("off_ctrl", 64'(rd), 64'h0);

    // Request dropped mid power-up: runs to RUN, then back to OFF
    ack_tie = 1'b1;
    apb_xfer(1, 12'h100, 32'h1, rd, e);
    repeat (2) @(posedge HCLK);
    #1;
    apb_xfer(1, 12'h100, 32'h0, rd, e);
    for (int n = 6; n <= 32; n++) begin
      @(posedge HCLK); #1;
      chk($sformatf("abort_fetch_E%0d", n), 64'(fen[0]), 64'(n == 4 + 2 * W));
    end
    apb_xfer(0, 12'h100, 0, rd, e);
    chk("abort_ctrl", 64'(rd), 64'h0);
    chk("abort_outs", 64'(cl_outs()), 64'h44);

    // Randomized register traffic against the model
    m_fcboot = 32'h1A000080; m_cs = '0; m_fetch = 0; m_lock = 0; m_jtag = '0;
    m_boot[0] = '0; m_boot[1] = '0; m_irq = '0;
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = int'($urandom_range(0, 22));
      a = {3'($urandom_range(0, 7)), offs[sel]};
      w = 1'($urandom_range(0, 1));
      if (offs[sel] == 9'h100 || offs[sel] == 9'h110) w = 1'b0;
      d = $urandom;
      if (offs[sel] == 9'h07C) d[0] = ($urandom_range(0, 19) == 0);
      model_acc(w, a, d, ee, erd);
      apb_xfer(w, a, d, rd, e);
      chk($sformatf("rnd%0d_err@%h", i, a), 64'(e), 64'(ee));
      if (!w) chk($sformatf("rnd%0d_rd@%h", i, a), 64'(rd), 64'(erd));
      chk($sformatf("rnd%0d_outs", i),
          {fc_bootaddr_o, 7'b0, fc_fetchen_o, 7'b0, eoc_o, 6'b0, irq, soc_jtag_reg_o},
          {m_fcboot, 7'b0, m_fetch, 7'b0, m_cs[31], 6'b0, m_irq, m_jtag});
      chk($sformatf("rnd%0d_boot", i), boot_o, {m_boot[1], m_boot[0]});
    end

    // Asynchronous reset in PWR_UP, then in RUN
    ack_tie = 1'b0; ack_man = 2'b00;
    apb_xfer(1, 12'h100, 32'h1, rd, e);
    repeat (3) @(posedge HCLK);
    #1;
    chk("pwrup_pow", 64'(pow[0]), 64'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst1_outs", 64'(cl_outs()), 64'h44);
    chk("arst1_fc", {fc_bootaddr_o, 30'b0, fc_fetchen_o, eoc_o}, {32'h1A000080, 32'h0});
    chk("arst1_boot", boot_o, 64'h0);
    #3 HRESETn = 1'b1;
    ack_tie = 1'b1;
    apb_xfer(1, 12'h110, 32'h1, rd, e);
    repeat (14) @(posedge HCLK);
    #1;
    chk("cl1_run", 64'(cl_outs()), 64'hB4);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst2_outs", 64'(cl_outs()), 64'h44);
    #3 HRESETn = 1'b1;

    run_vecs(n_t1, vt.size());
    chk("eoc", 64'(eoc_o), 64'h1);
    chk("fcboot_kept", 64'(fc_bootaddr_o), 64'h1A000080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
